mc_controller_hs: RTL and testbench

Parametrised multi-cycle CPU control FSM, successor to the fixed-latency controller. It sits between the instruction register (OpCode/Funct) and the datapath, and drives the same datapath control bundle. It adds three things: a ready handshake on every memory access, a bus-timeout trap, and an exception state that redirects the PC to the exception vector. Exceptions are raised by illegal opcodes, bus timeout or an external interrupt.

---
 rtl/mc_controller_hs.sv | 252 +++++++++++++++++++++++++
 tb/tb_mc_controller_hs.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_hs.sv
// Multi-cycle CPU control FSM with a memory ready handshake, bus-timeout trap,
// illegal-opcode trap, interrupt redirect and an exception state (PC <- vector).
module mc_controller_hs #(
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 15,
  parameter bit          IRQ_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  input  logic       irq,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       EPCWrite,
  output logic       CauseWrite,
  output logic [1:0] Cause,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;

  logic is_r, is_j, is_jal, is_beq, is_lw, is_sw, is_imm, is_lui, is_andi, is_slt, legal;
  logic fn_shift, fn_jr, fn_jalr;
  logic timeout, exit_to_if;

  assign is_r     = (OpCode == OP_R);
  assign is_j     = (OpCode == OP_J);
  assign is_jal   = (OpCode == OP_JAL);
  assign is_beq   = (OpCode == OP_BEQ);
  assign is_lw    = (OpCode == OP_LW);
  assign is_sw    = (OpCode == OP_SW);
  assign is_lui   = (OpCode == OP_LUI);
  assign is_andi  = (OpCode == OP_ANDI);
  assign is_slt   = (OpCode == OP_SLTI) || (OpCode == OP_SLTIU);
  assign is_imm   = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) || is_slt || is_andi || is_lui;
  assign legal    = is_r || is_j || is_jal || is_beq || is_lw || is_sw || is_imm;
  assign fn_shift = (Funct == 6'h00) || (Funct == 6'h02) || (Funct == 6'h03);
  assign fn_jr    = (Funct == 6'h08);
  assign fn_jalr  = (Funct == 6'h09);

  // A completing access on the very cycle the counter reaches the limit wins over the trap.
  assign timeout  = (MAX_WAIT != 0) && (wait_q == MAX_W) && !mem_ready;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    EPCWrite    = 1'b0;
    CauseWrite  = 1'b0;
    state_d     = state_q;
    cause_d     = cause_q;
    exit_to_if  = 1'b0;

    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (timeout) begin
          state_d = S_EXC;
          cause_d = 2'b10;
        end else if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        if (legal) begin
          state_d = S_EX;
        end else begin
          state_d = S_EXC;
          cause_d = 2'b01;
        end
      end
      S_EX: begin
        if (is_j) begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          exit_to_if = 1'b1;
        end else if (is_jal) begin
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
          RegWrite = 1'b1;
          state_d  = S_WB;
        end else if (is_beq) begin
          PCWriteCond = 1'b1;
          ALUSrcA     = 2'b01;
          PCSource    = 2'b01;
          exit_to_if  = 1'b1;
        end else if (is_r) begin
          ALUSrcA = fn_shift ? 2'b10 : 2'b01;
          if (fn_jr) begin
            PCWrite    = 1'b1;
            exit_to_if = 1'b1;
          end else begin
            if (fn_jalr) begin
              RegDst   = 2'b01;
              RegWrite = 1'b1;
            end
            state_d = S_WB;
          end
        end else if (is_lw || is_sw) begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          state_d = S_MEM;
        end else if (is_imm) begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ExtOp   = 1'b1;
          LuiOp   = is_lui;
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (timeout) begin
          state_d = S_EXC;
          cause_d = 2'b10;
        end else if (mem_ready) begin
          if (is_lw) state_d = S_WB;
          else       exit_to_if = 1'b1;
        end
      end
      S_WB: begin
        if (is_jal || (is_r && fn_jalr)) begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end else if (is_r) begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
        end else if (is_lw) begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end else if (is_imm) begin
          RegWrite = 1'b1;
        end
        exit_to_if = 1'b1;
      end
      S_EXC: begin
        EPCWrite   = 1'b1;
        CauseWrite = 1'b1;
        PCWrite    = 1'b1;
        PCSource   = 2'b11;
        state_d    = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Interrupts are taken only at an instruction boundary, after the PC update.
    if (exit_to_if) begin
      if (IRQ_EN && irq) begin
        state_d = S_EXC;
        cause_d = 2'b00;
      end else begin
        state_d = S_IF;
      end
    end
  end

  always_comb begin
    ALUOp[3]   = OpCode[0];
    ALUOp[2:0] = 3'b000;
    if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
      if (is_r)         ALUOp[2:0] = 3'b010;
      else if (is_beq)  ALUOp[2:0] = 3'b001;
      else if (is_andi) ALUOp[2:0] = 3'b100;
      else if (is_slt)  ALUOp[2:0] = 3'b101;
    end
  end

  always_comb begin
    if (state_d != state_q)
      wait_d = '0;
    else if ((state_q == S_IF || state_q == S_MEM) && !mem_ready && (wait_q != '1))
      wait_d = wait_q + 1'b1;
    else
      wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IF;
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  assign state_o = state_q;
  assign Cause   = (state_q == S_EXC) ? cause_q : 2'b00;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench for mc_controller_hs: every cycle's full control word is
// compared against a hand-built expected word.
module tb_mc_controller_hs;

  logic       clk = 1'b0;
  logic       reset, reset_b;
  logic [5:0] OpCode, Funct;
  logic       mem_ready, mem_ready_b, irq;

  logic PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, Cause;
  logic [3:0] ALUOp;
  logic EPCWrite, CauseWrite;
  logic [2:0] state_o;

  logic PCWrite_b, PCWriteCond_b, IorD_b, MemWrite_b, MemRead_b, IRWrite_b, RegWrite_b, ExtOp_b, LuiOp_b;
  logic [1:0] MemtoReg_b, RegDst_b, ALUSrcA_b, ALUSrcB_b, PCSource_b, Cause_b;
  logic [3:0] ALUOp_b;
  logic EPCWrite_b, CauseWrite_b;
  logic [2:0] state_o_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_controller_hs #(.WAIT_W(4), .MAX_WAIT(15), .IRQ_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready), .irq(irq),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemWrite(MemWrite),
    .MemRead(MemRead), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite),
    .Cause(Cause), .state_o(state_o)
  );

  mc_controller_hs #(.WAIT_W(4), .MAX_WAIT(0), .IRQ_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready_b), .irq(irq),
    .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .IorD(IorD_b), .MemWrite(MemWrite_b),
    .MemRead(MemRead_b), .IRWrite(IRWrite_b), .RegWrite(RegWrite_b), .ExtOp(ExtOp_b), .LuiOp(LuiOp_b),
    .MemtoReg(MemtoReg_b), .RegDst(RegDst_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b),
    .PCSource(PCSource_b), .ALUOp(ALUOp_b), .EPCWrite(EPCWrite_b), .CauseWrite(CauseWrite_b),
    .Cause(Cause_b), .state_o(state_o_b)
  );

  // Packed view of all outputs; field positions match the helpers below.
  logic [31:0] ctl, ctl_b;
  assign ctl = {2'b00, PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite, RegWrite, ExtOp, LuiOp,
                EPCWrite, CauseWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, Cause, state_o};
  assign ctl_b = {2'b00, PCWrite_b, PCWriteCond_b, IorD_b, MemWrite_b, MemRead_b, IRWrite_b, RegWrite_b,
                  ExtOp_b, LuiOp_b, EPCWrite_b, CauseWrite_b, MemtoReg_b, RegDst_b, ALUSrcA_b, ALUSrcB_b,
                  PCSource_b, ALUOp_b, Cause_b, state_o_b};

  localparam logic [31:0] CW   = 32'd1 << 19;
  localparam logic [31:0] EW   = 32'd1 << 20;
  localparam logic [31:0] LUI  = 32'd1 << 21;
  localparam logic [31:0] EXT  = 32'd1 << 22;
  localparam logic [31:0] RW   = 32'd1 << 23;
  localparam logic [31:0] IRW  = 32'd1 << 24;
  localparam logic [31:0] MR   = 32'd1 << 25;
  localparam logic [31:0] MW   = 32'd1 << 26;
  localparam logic [31:0] IOD  = 32'd1 << 27;
  localparam logic [31:0] PCWC = 32'd1 << 28;
  localparam logic [31:0] PCW  = 32'd1 << 29;

  function automatic logic [31:0] st(input int v);  return 32'(v) << 0;  endfunction
  function automatic logic [31:0] cz(input int v);  return 32'(v) << 3;  endfunction
  function automatic logic [31:0] alu(input int v); return 32'(v) << 5;  endfunction
  function automatic logic [31:0] pcs(input int v); return 32'(v) << 9;  endfunction
  function automatic logic [31:0] sb(input int v);  return 32'(v) << 11; endfunction
  function automatic logic [31:0] sa(input int v);  return 32'(v) << 13; endfunction
  function automatic logic [31:0] rd(input int v);  return 32'(v) << 15; endfunction
  function automatic logic [31:0] mr(input int v);  return 32'(v) << 17; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [31:0] exp);
    @(negedge clk);
    chk(tag, ctl, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic cycb(input string tag, input logic [31:0] exp);
    @(negedge clk);
    chk(tag, ctl_b, exp);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] if0, if1, id0, id1, exc_v;

  initial begin
    if0   = MR | IRW | PCW | sb(1);
    if1   = if0 | alu(8);
    id0   = sb(3) | st(1);
    id1   = id0 | alu(8);
    exc_v = EW | CW | PCW | pcs(3) | st(5);

    reset = 1'b0; reset_b = 1'b0; OpCode = 6'h00; Funct = 6'h20;
    mem_ready = 1'b0; mem_ready_b = 1'b1; irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cyc("reset_if", MR | sb(1));
    reset = 1'b1; mem_ready = 1'b1;

    OpCode = 6'h23;
    cyc("lw_if", if1); cyc("lw_id", id1);
    cyc("lw_ex", sa(1) | sb(2) | alu(8) | st(2));
    cyc("lw_mem", IOD | MR | alu(8) | st(3));
    cyc("lw_wb", RW | mr(1) | alu(8) | st(4));

    OpCode = 6'h2b;
    cyc("sw_if", if1); cyc("sw_id", id1);
    cyc("sw_ex", sa(1) | sb(2) | alu(8) | st(2));
    cyc("sw_mem", IOD | MW | alu(8) | st(3));

    OpCode = 6'h00; Funct = 6'h20;
    cyc("add_if", if0); cyc("add_id", id0);
    cyc("add_ex", sa(1) | alu(2) | st(2));
    cyc("add_wb", RW | rd(1) | alu(2) | st(4));

    OpCode = 6'h04;
    cyc("beq_if", if0); cyc("beq_id", id0);
    cyc("beq_ex", PCWC | sa(1) | pcs(1) | alu(1) | st(2));

    OpCode = 6'h02;
    cyc("j_if", if0); cyc("j_id", id0);
    cyc("j_ex", PCW | pcs(2) | st(2));

    OpCode = 6'h03;
    cyc("jal_if", if1); cyc("jal_id", id1);
    cyc("jal_ex", RW | rd(2) | mr(2) | alu(8) | st(2));
    cyc("jal_wb", PCW | pcs(2) | alu(8) | st(4));

    OpCode = 6'h00; Funct = 6'h00;
    cyc("sll_if", if0); cyc("sll_id", id0);
    cyc("sll_ex", sa(2) | alu(2) | st(2));
    cyc("sll_wb", RW | rd(1) | alu(2) | st(4));

    Funct = 6'h08;
    cyc("jr_if", if0); cyc("jr_id", id0);
    cyc("jr_ex", PCW | sa(1) | alu(2) | st(2));

    Funct = 6'h09;
    cyc("jalr_if", if0); cyc("jalr_id", id0);
    cyc("jalr_ex", RW | rd(1) | sa(1) | alu(2) | st(2));
    cyc("jalr_wb", PCW | pcs(2) | alu(2) | st(4));

    OpCode = 6'h0f;
    cyc("lui_if", if1); cyc("lui_id", id1);
    cyc("lui_ex", EXT | LUI | sa(1) | sb(2) | alu(8) | st(2));
    cyc("lui_wb", RW | alu(8) | st(4));

    OpCode = 6'h0c;
    cyc("andi_if", if0); cyc("andi_id", id0);
    cyc("andi_ex", EXT | sa(1) | sb(2) | alu(4) | st(2));
    cyc("andi_wb", RW | alu(4) | st(4));

    OpCode = 6'h0b;
    cyc("sltiu_if", if1); cyc("sltiu_id", id1);
    cyc("sltiu_ex", EXT | sa(1) | sb(2) | alu(13) | st(2));
    cyc("sltiu_wb", RW | alu(13) | st(4));

    // lw with three wait cycles in MEM: 8 cycles overall
    OpCode = 6'h23;
    cyc("lww_if", if1); cyc("lww_id", id1);
    cyc("lww_ex", sa(1) | sb(2) | alu(8) | st(2));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lww_mem_wait", IOD | MR | alu(8) | st(3));
    mem_ready = 1'b1;
    cyc("lww_mem_done", IOD | MR | alu(8) | st(3));
    cyc("lww_wb", RW | mr(1) | alu(8) | st(4));

    // IF stuck low: 15 waits counted, trap on the cycle the counter equals 15
    OpCode = 6'h00; Funct = 6'h20; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to_if_wait", MR | sb(1));
    cyc("to_exc", exc_v | cz(2));
    mem_ready = 1'b1;
    cyc("to_back_if", if0);
    cyc("to_back_id", id0);
    cyc("to_back_ex", sa(1) | alu(2) | st(2));
    cyc("to_back_wb", RW | rd(1) | alu(2) | st(4));

    // ready arriving exactly at the limit completes the fetch
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("lim_if_wait", MR | sb(1));
    mem_ready = 1'b1;
    cyc("lim_if_done", if0);
    cyc("lim_id", id0);
    cyc("lim_ex", sa(1) | alu(2) | st(2));
    cyc("lim_wb", RW | rd(1) | alu(2) | st(4));

    OpCode = 6'h3f;
    cyc("ill_if", if1); cyc("ill_id", id1);
    cyc("ill_exc", exc_v | cz(1) | alu(8));

    OpCode = 6'h08;
    cyc("irq_if", if0); cyc("irq_id", id0);
    cyc("irq_ex", EXT | sa(1) | sb(2) | st(2));
    irq = 1'b1;
    cyc("irq_wb", RW | st(4));
    cyc("irq_exc", exc_v | cz(0));
    cyc("irq_no_nest_if", if0);
    irq = 1'b0;
    cyc("irq_id2", id0);
    cyc("irq_ex2", EXT | sa(1) | sb(2) | st(2));
    cyc("irq_wb2", RW | st(4));

    // reset while sw waits in MEM
    OpCode = 6'h2b;
    cyc("rsw_if", if1); cyc("rsw_id", id1);
    cyc("rsw_ex", sa(1) | sb(2) | alu(8) | st(2));
    mem_ready = 1'b0;
    cyc("rsw_mem", IOD | MW | alu(8) | st(3));
    reset = 1'b0;
    cyc("rsw_mem_rst", IOD | MW | alu(8) | st(3));
    reset = 1'b1;
    cyc("rsw_after_rst", MR | sb(1) | alu(8));
    mem_ready = 1'b1;
    cyc("rsw_if_again", if1);

    // second instance: interrupts and timeout disabled
    reset = 1'b0; reset_b = 1'b1; mem_ready_b = 1'b1; OpCode = 6'h08;
    cycb("b_if", if0); cycb("b_id", id0);
    cycb("b_ex", EXT | sa(1) | sb(2) | st(2));
    irq = 1'b1;
    cycb("b_wb", RW | st(4));
    cycb("b_noirq_if", if0);
    irq = 1'b0;
    cycb("b_id2", id0);
    cycb("b_ex2", EXT | sa(1) | sb(2) | st(2));
    cycb("b_wb2", RW | st(4));
    mem_ready_b = 1'b0;
    for (int i = 0; i < 20; i++) cycb("b_nowait_trap", MR | sb(1));
    mem_ready_b = 1'b1;
    cycb("b_if_done", if0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
